shift_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-mode shift-right register.
- Shifts an N-bit word by a variable amount in one of four modes: logical right, logical left, arithmetic right, rotate right.
- Implemented as AMT_N registered barrel stages with a valid/ready handshake and global enable.
- Sits between operand registers and the ALU result mux in the datapath catalog.

---
 rtl/shift_pipe.sv | 136 +++++++++++++
 tb/tb_shift_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SRL/SLL/SRA/ROR), one registered stage per amount bit.
// Define SHIFT_STICKY_EN to add the sticky output (OR of all bits shifted out).
module shift_pipe #(
  parameter int N     = 8,
  parameter int AMT_N = 3   // must equal $clog2(N); N a power of two
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     d_i,
  input  logic [AMT_N-1:0] amt_i,
  input  logic [1:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     out_o
`ifdef SHIFT_STICKY_EN
  ,
  output logic             sticky_o
`endif
);

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  logic advance;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign in_ready_o = en_i && (!out_valid_o || out_ready_i);
  assign advance    = in_ready_o;

  for (genvar k = 0; k < AMT_N; k++) begin : g_stage
    localparam int S = 1 << k;

    logic [N-1:0]       srcData;
    logic [AMT_N-k-1:0] srcAmt;
    logic [1:0]         srcMode;
    logic               srcValid;
    logic [N-1:0]       data_d;
    logic [N-1:0]       data_q;
    logic               valid_q;

    if (k == 0) begin : g_head
      assign srcData  = d_i;
      assign srcAmt   = amt_i;
      assign srcMode  = mode_i;
      assign srcValid = in_valid_i;
    end else begin : g_body
      assign srcData  = g_stage[k-1].data_q;
      assign srcAmt   = g_stage[k-1].g_carry.amt_q;
      assign srcMode  = g_stage[k-1].g_carry.mode_q;
      assign srcValid = g_stage[k-1].valid_q;
    end

    always_comb begin
      data_d = srcData;
      if (srcAmt[0]) begin
        case (srcMode)
          MODE_SRL: data_d = srcData >> S;
          MODE_SLL: data_d = srcData << S;
          MODE_SRA: data_d = $signed(srcData) >>> S;
          default:  data_d = (srcData >> S) | (srcData << (N - S));
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (advance) begin
        data_q  <= data_d;
        valid_q <= srcValid;
      end
    end

    // Only the amount bits still to be applied travel on; the last stage needs none.
    if (k < AMT_N - 1) begin : g_carry
      logic [AMT_N-k-2:0] amt_q;
      logic [1:0]         mode_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          amt_q  <= '0;
          mode_q <= '0;
        end else if (advance) begin
          amt_q  <= srcAmt[AMT_N-k-1:1];
          mode_q <= srcMode;
        end
      end
    end

`ifdef SHIFT_STICKY_EN
    localparam logic [N-1:0] LOW_MASK  = {N{1'b1}} >> (N - S);
    localparam logic [N-1:0] HIGH_MASK = ~({N{1'b1}} >> S);

    logic stickyIn;
    logic sticky_d;
    logic sticky_q;

    if (k == 0) begin : g_sticky_head
      assign stickyIn = 1'b0;
    end else begin : g_sticky_body
      assign stickyIn = g_stage[k-1].sticky_q;
    end

    always_comb begin
      sticky_d = stickyIn;
      if (srcAmt[0]) begin
        case (srcMode)
          MODE_SRL, MODE_SRA: sticky_d = stickyIn | (|(srcData & LOW_MASK));
          MODE_SLL:           sticky_d = stickyIn | (|(srcData & HIGH_MASK));
          default:            sticky_d = stickyIn;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sticky_q <= 1'b0;
      end else if (advance) begin
        sticky_q <= sticky_d;
      end
    end
`endif
  end

  assign out_valid_o = g_stage[AMT_N-1].valid_q;
  assign out_o       = g_stage[AMT_N-1].data_q;
`ifdef SHIFT_STICKY_EN
  assign sticky_o    = g_stage[AMT_N-1].sticky_q;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed scenarios plus a random stream,
// with expected results queued at acceptance and compared when the output is taken.
module tb_shift_pipe;

   typedef struct packed {
      logic [7:0] data;
      logic       st;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       inValid;
   logic       inReady;
   logic [7:0] d;
   logic [2:0] amt;
   logic [1:0] mode;
   logic       outValid;
   logic       outReady;
   logic [7:0] outData;
   logic       stickyObs;

   exp_t expQ[$];
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   shift_pipe #(.N(8), .AMT_N(3)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .in_valid_i  (inValid),
      .in_ready_o  (inReady),
      .d_i         (d),
      .amt_i       (amt),
      .mode_i      (mode),
      .out_valid_o (outValid),
      .out_ready_i (outReady),
      .out_o       (outData)
`ifdef SHIFT_STICKY_EN
      ,
      .sticky_o    (stickyObs)
`endif
   );

`ifndef SHIFT_STICKY_EN
   assign stickyObs = 1'b0;
`endif

   // Bit-at-a-time reference shifter, independent of the barrel structure.
   function automatic exp_t model(input logic [7:0] x, input logic [2:0] a, input logic [1:0] m);
      exp_t r;
      logic [7:0] v;
      logic lost;
      v = x;
      lost = 1'b0;
      for (int i = 0; i < int'(a); i++) begin
         case (m)
            2'b00: begin lost = lost | v[0]; v = {1'b0, v[7:1]}; end
            2'b01: begin lost = lost | v[7]; v = {v[6:0], 1'b0}; end
            2'b10: begin lost = lost | v[0]; v = {v[7], v[7:1]}; end
            default: v = {v[0], v[7:1]};
         endcase
      end
      r.data = v;
      r.st = lost;
      return r;
   endfunction

   task automatic applyStimulus(input logic v, input logic [7:0] dd, input logic [2:0] aa,
                                input logic [1:0] mm, input logic er, input logic oe);
      inValid  = v;
      d        = dd;
      amt      = aa;
      mode     = mm;
      en       = er;
      outReady = oe;
   endtask

   // One clock: queue the expectation if the input is accepted, report any output transfer.
   task automatic cycle(input exp_t e, output logic acc, output logic adv,
                        output logic took, output exp_t got);
      #1;
`ifndef SHIFT_STICKY_EN
      e.st = 1'b0;
`endif
      adv  = inReady;
      acc  = inValid && inReady;
      if (acc) expQ.push_back(e);
      took = outValid && outReady && inReady;
      got  = '{data: outData, st: stickyObs};
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      #1;
      vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b, required 0", outValid); end
      vecs++; if (outData !== 8'h00) begin errs++; $display("FAIL reset_out: got %h, required 00", outData); end
      vecs++; if (inReady !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b, required 1", inReady); end
`ifdef SHIFT_STICKY_EN
      vecs++; if (stickyObs !== 1'b0) begin errs++; $display("FAIL reset_sticky: got %b, required 0", stickyObs); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_srl;
      exp_t got, want;
      logic acc, adv, took;
      int accAt = -1;
      int lat = -1;
      for (int c = 0; c < 12 && lat < 0; c++) begin
         if (c == 0) applyStimulus(1'b1, 8'b1011_0110, 3'd3, 2'b00, 1'b1, 1'b1);
         else        applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, 1'b1);
         cycle('{data: 8'b0001_0110, st: 1'b1}, acc, adv, took, got);
         if (acc) accAt = c;
         if (took) begin
            lat = c - accAt;
            vecs++;
            if (expQ.size() == 0) begin errs++; $display("FAIL srl_out: got %h, required no result", got.data); end
            else begin
               want = expQ.pop_front();
               if (got !== want) begin errs++; $display("FAIL srl_out: got %h sticky %b, required %h sticky %b", got.data, got.st, want.data, want.st); end
            end
         end
      end
      vecs++; if (lat !== 3) begin errs++; $display("FAIL srl_latency: got %0d, required 3", lat); end
   endtask

   task automatic test_sra;
      exp_t got, want;
      logic acc, adv, took;
      logic [7:0] ds[2] = '{8'b1000_0001, 8'b0111_0000};
      logic [2:0] as[2] = '{3'd7, 3'd4};
      exp_t exps[2] = '{'{data: 8'hFF, st: 1'b1}, '{data: 8'h07, st: 1'b0}};
      int taken = 0;
      for (int c = 0; c < 15 && taken < 2; c++) begin
         if (c < 2) applyStimulus(1'b1, ds[c], as[c], 2'b10, 1'b1, 1'b1);
         else       applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, 1'b1);
         cycle(exps[(c < 2) ? c : 0], acc, adv, took, got);
         if (took) begin
            taken++;
            vecs++;
            if (expQ.size() == 0) begin errs++; $display("FAIL sra_out: got %h, required no result", got.data); end
            else begin
               want = expQ.pop_front();
               if (got !== want) begin errs++; $display("FAIL sra_out: got %h sticky %b, required %h sticky %b", got.data, got.st, want.data, want.st); end
            end
         end
      end
      vecs++; if (taken !== 2) begin errs++; $display("FAIL sra_count: got %0d results, required 2", taken); end
   endtask

   task automatic test_back_to_back;
      exp_t got, want;
      logic acc, adv, took;
      logic [1:0] ms[2] = '{2'b01, 2'b11};
      exp_t exps[2] = '{'{data: 8'h0C, st: 1'b1}, '{data: 8'hF0, st: 1'b0}};
      int taken = 0;
      int firstAt = -1;
      int lastAt = -1;
      for (int c = 0; c < 15 && taken < 2; c++) begin
         if (c < 2) applyStimulus(1'b1, 8'hC3, 3'd2, ms[c], 1'b1, 1'b1);
         else       applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, 1'b1);
         cycle(exps[(c < 2) ? c : 0], acc, adv, took, got);
         if (took) begin
            taken++;
            if (firstAt < 0) firstAt = c;
            lastAt = c;
            vecs++;
            if (expQ.size() == 0) begin errs++; $display("FAIL b2b_out: got %h, required no result", got.data); end
            else begin
               want = expQ.pop_front();
               if (got !== want) begin errs++; $display("FAIL b2b_out: got %h sticky %b, required %h sticky %b", got.data, got.st, want.data, want.st); end
            end
         end
      end
      vecs++; if (taken !== 2) begin errs++; $display("FAIL b2b_count: got %0d results, required 2", taken); end
      vecs++; if (lastAt - firstAt !== 1) begin errs++; $display("FAIL b2b_spacing: got %0d cycles apart, required 1", lastAt - firstAt); end
   endtask

   task automatic test_backpressure;
      exp_t got, want;
      logic acc, adv, took;
      logic [7:0] ds[5];
      logic [2:0] as[5];
      logic [1:0] ms[5];
      int idx = 0;
      int taken = 0;
      int firstAt = -1;
      int lastAt = -1;
      for (int i = 0; i < 5; i++) begin
         ds[i] = 8'($urandom);
         as[i] = 3'($urandom_range(1, 7));
         ms[i] = 2'($urandom);
      end
      for (int c = 0; c < 10; c++) begin
         applyStimulus(idx < 5, ds[(idx < 5) ? idx : 0], as[(idx < 5) ? idx : 0], ms[(idx < 5) ? idx : 0], 1'b1, 1'b0);
         cycle(model(ds[(idx < 5) ? idx : 0], as[(idx < 5) ? idx : 0], ms[(idx < 5) ? idx : 0]), acc, adv, took, got);
         if (acc) idx++;
         vecs++; if (took) begin errs++; $display("FAIL bp_leak: got transfer of %h, required none while out_ready=0", got.data); end
      end
      vecs++; if (idx !== 3) begin errs++; $display("FAIL bp_fill: got %0d accepted, required 3", idx); end
      for (int h = 0; h < 3; h++) begin
         #1;
         vecs++; if (inReady !== 1'b0) begin errs++; $display("FAIL bp_ready: got %b, required 0", inReady); end
         vecs++; if (outValid !== 1'b1 || outData !== expQ[0].data) begin errs++; $display("FAIL bp_hold: got valid %b out %h, required 1 %h", outValid, outData, expQ[0].data); end
         cycle(model(ds[idx], as[idx], ms[idx]), acc, adv, took, got);
      end
      for (int c = 0; c < 30 && taken < 5; c++) begin
         applyStimulus(idx < 5, ds[(idx < 5) ? idx : 0], as[(idx < 5) ? idx : 0], ms[(idx < 5) ? idx : 0], 1'b1, 1'b1);
         cycle(model(ds[(idx < 5) ? idx : 0], as[(idx < 5) ? idx : 0], ms[(idx < 5) ? idx : 0]), acc, adv, took, got);
         if (acc) idx++;
         if (took) begin
            taken++;
            if (firstAt < 0) firstAt = c;
            lastAt = c;
            vecs++;
            if (expQ.size() == 0) begin errs++; $display("FAIL bp_out: got %h, required no result", got.data); end
            else begin
               want = expQ.pop_front();
               if (got !== want) begin errs++; $display("FAIL bp_out: got %h sticky %b, required %h sticky %b", got.data, got.st, want.data, want.st); end
            end
         end
      end
      vecs++; if (taken !== 5) begin errs++; $display("FAIL bp_count: got %0d results, required 5", taken); end
      vecs++; if (lastAt - firstAt !== 4) begin errs++; $display("FAIL bp_rate: got span %0d cycles, required 4", lastAt - firstAt); end
   endtask

   task automatic test_enable;
      exp_t got, want;
      logic acc, adv, took;
      logic [7:0] ds[6];
      logic [2:0] as[6];
      logic [1:0] ms[6];
      int accAdv[$];
      int advCount = 0;
      int idx = 0;
      int taken = 0;
      int lat;
      logic enNow;
      for (int i = 0; i < 6; i++) begin
         ds[i] = 8'($urandom);
         as[i] = 3'($urandom);
         ms[i] = 2'($urandom);
      end
      for (int c = 0; c < 30 && taken < 6; c++) begin
         enNow = !(c >= 4 && c < 8);
         applyStimulus(idx < 6, ds[(idx < 6) ? idx : 0], as[(idx < 6) ? idx : 0], ms[(idx < 6) ? idx : 0], enNow, 1'b1);
         if (!enNow) begin
            #1;
            vecs++; if (inReady !== 1'b0) begin errs++; $display("FAIL en_ready: got %b, required 0", inReady); end
            vecs++; if (outValid !== 1'b1 || outData !== expQ[0].data) begin errs++; $display("FAIL en_hold: got valid %b out %h, required 1 %h", outValid, outData, expQ[0].data); end
         end
         cycle(model(ds[(idx < 6) ? idx : 0], as[(idx < 6) ? idx : 0], ms[(idx < 6) ? idx : 0]), acc, adv, took, got);
         if (acc) begin idx++; accAdv.push_back(advCount); end
         if (took) begin
            taken++;
            vecs++;
            if (expQ.size() == 0 || accAdv.size() == 0) begin errs++; $display("FAIL en_out: got %h, required no result", got.data); end
            else begin
               want = expQ.pop_front();
               lat = advCount - accAdv.pop_front();
               if (got !== want) begin errs++; $display("FAIL en_out: got %h sticky %b, required %h sticky %b", got.data, got.st, want.data, want.st); end
               vecs++; if (lat !== 3) begin errs++; $display("FAIL en_latency: got %0d active cycles, required 3", lat); end
            end
         end
         if (adv) advCount++;
      end
      vecs++; if (taken !== 6) begin errs++; $display("FAIL en_count: got %0d results, required 6", taken); end
   endtask

   task automatic test_reset_midflight;
      exp_t got, want;
      logic acc, adv, took;
      int taken = 0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 8'($urandom), 3'($urandom), 2'($urandom), 1'b1, 1'b1);
         cycle(model(d, amt, mode), acc, adv, took, got);
      end
      applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %b, required 0", outValid); end
      vecs++; if (outData !== 8'h00) begin errs++; $display("FAIL rstmid_out: got %h, required 00", outData); end
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cycle(model(8'h00, 3'd0, 2'b00), acc, adv, took, got);
         vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL rstmid_stale: got out_valid %b out %h, required 0", outValid, outData); end
      end
      for (int c = 0; c < 15 && taken < 4; c++) begin
         applyStimulus(c < 4, 8'h5A, 3'd0, 2'(c), 1'b1, 1'b1);
         cycle('{data: 8'h5A, st: 1'b0}, acc, adv, took, got);
         if (took) begin
            taken++;
            vecs++;
            if (expQ.size() == 0) begin errs++; $display("FAIL amt0_out: got %h, required no result", got.data); end
            else begin
               want = expQ.pop_front();
               if (got !== want) begin errs++; $display("FAIL amt0_out: got %h sticky %b, required %h sticky %b", got.data, got.st, want.data, want.st); end
            end
         end
      end
      vecs++; if (taken !== 4) begin errs++; $display("FAIL amt0_count: got %0d results, required 4", taken); end
   endtask

   task automatic test_random;
      exp_t got, want;
      logic acc, adv, took;
      for (int c = 0; c < 70; c++) begin
         if (c < 50) applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom), 2'($urandom),
                                  $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
         else        applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, 1'b1);
         cycle(model(d, amt, mode), acc, adv, took, got);
         if (took) begin
            vecs++;
            if (expQ.size() == 0) begin errs++; $display("FAIL rand_out: got %h, required no result", got.data); end
            else begin
               want = expQ.pop_front();
               if (got !== want) begin errs++; $display("FAIL rand_out: got %h sticky %b, required %h sticky %b", got.data, got.st, want.data, want.st); end
            end
         end
      end
      vecs++; if (expQ.size() !== 0) begin errs++; $display("FAIL rand_drain: got %0d results outstanding, required 0", expQ.size()); end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 3'd0, 2'b00, 1'b1, 1'b1);
      test_reset;
      test_srl;
      test_sra;
      test_back_to_back;
      test_backpressure;
      test_enable;
      test_reset_midflight;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
